// File: rtl/dca_matrix_lsu_rdata_aligner.sv
// Gathers the AXI R beats of one row transaction, right-aligns them by the start bit offset
// and zero-fills masked columns. Optional rresp checking: DCA_RDATA_ALIGNER_RRESP_CHECK_EN.
module dca_matrix_lsu_rdata_aligner #(
    parameter int unsigned BW_AXI_DATA    = 32,
    parameter int unsigned BW_ROW_BUFFER  = 128,
    parameter int unsigned MATRIX_NUM_COL = 4
) (
    input  logic                           clk,
    input  logic                           rstnn,
    input  logic                           txn_valid,
    output logic                           txn_ready,
    input  logic [$clog2(BW_AXI_DATA)-1:0] txn_bitoffset,
    input  logic [7:0]                     txn_alen,
    input  logic [2:0]                     txn_addr_lsa_p3,
    input  logic [MATRIX_NUM_COL-1:0]      txn_col_mask,
    input  logic                           rvalid,
    output logic                           rready,
    input  logic [BW_AXI_DATA-1:0]         rdata,
    input  logic [1:0]                     rresp,
    input  logic                           rlast,
    output logic                           row_valid,
    input  logic                           row_ready,
    output logic [BW_ROW_BUFFER-1:0]       row_data,
    output logic                           err_flag,
    input  logic                           err_clear
);

    localparam int unsigned MAX_BEAT = BW_ROW_BUFFER / BW_AXI_DATA + 1;
    localparam int unsigned BUF_W    = MAX_BEAT * BW_AXI_DATA;
    localparam int unsigned OFS_W    = $clog2(BW_AXI_DATA);
    localparam int unsigned CNT_W    = 9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_ALIGN,
        S_OUTPUT
    } state_t;

    state_t                    state_q, state_d;
    logic [OFS_W-1:0]          ofs_q, ofs_d;
    logic [7:0]                alen_q, alen_d;
    logic [2:0]                lsa_q, lsa_d;
    logic [MATRIX_NUM_COL-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BUF_W-1:0]          gbuf_q, gbuf_d;
    logic [BW_ROW_BUFFER-1:0]  row_q, row_d;
    logic                      err_q, err_d;

    logic                      beat_acc;
    logic                      err_set;
    logic [BUF_W-1:0]          shifted;
    logic [BW_ROW_BUFFER-1:0]  col_bits;

    assign beat_acc = (state_q == S_COLLECT) && rvalid;
    assign shifted  = gbuf_q >> ofs_q;

    // Column of bit j is j >> lsa; columns past the mask width shift out to zero.
    always_comb begin
        logic [MATRIX_NUM_COL-1:0] msh;
        col_bits = '0;
        msh      = '0;
        for (int unsigned j = 0; j < BW_ROW_BUFFER; j++) begin
            msh         = mask_q >> (j >> lsa_q);
            col_bits[j] = msh[0];
        end
    end

`ifdef DCA_RDATA_ALIGNER_RRESP_CHECK_EN
    assign err_set = beat_acc &&
                     ((rlast && (cnt_q != {1'b0, alen_q})) || (rresp != 2'b00));
`else
    logic unused_rresp;
    assign unused_rresp = ^rresp;
    assign err_set      = beat_acc && rlast && (cnt_q != {1'b0, alen_q});
`endif

    assign err_d = err_set | (err_q & ~err_clear);

    always_comb begin
        state_d = state_q;
        ofs_d   = ofs_q;
        alen_d  = alen_q;
        lsa_d   = lsa_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        gbuf_d  = gbuf_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                if (txn_valid) begin
                    ofs_d   = txn_bitoffset;
                    alen_d  = txn_alen;
                    lsa_d   = (txn_addr_lsa_p3 > 3'd5) ? 3'd5 : txn_addr_lsa_p3;
                    mask_d  = txn_col_mask;
                    cnt_d   = '0;
                    gbuf_d  = '0;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (rvalid) begin
                    // Beats past the gather depth match no slot and are dropped.
                    for (int unsigned b = 0; b < MAX_BEAT; b++) begin
                        if (cnt_q == CNT_W'(b)) begin
                            gbuf_d[b*BW_AXI_DATA +: BW_AXI_DATA] = rdata;
                        end
                    end
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (rlast) begin
                        state_d = S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                row_d   = shifted[BW_ROW_BUFFER-1:0] & col_bits;
                state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (row_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q <= S_IDLE;
            ofs_q   <= '0;
            alen_q  <= '0;
            lsa_q   <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            gbuf_q  <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ofs_q   <= ofs_d;
            alen_q  <= alen_d;
            lsa_q   <= lsa_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            gbuf_q  <= gbuf_d;
            row_q   <= row_d;
            err_q   <= err_d;
        end
    end

    assign txn_ready = (state_q == S_IDLE);
    assign rready    = (state_q == S_COLLECT);
    assign row_valid = (state_q == S_OUTPUT);
    assign row_data  = row_q;
    assign err_flag  = err_q;

endmodule

// File: tb/tb_dca_matrix_lsu_rdata_aligner.sv
// Directed-vector bench for dca_matrix_lsu_rdata_aligner; expected rows are hand-computed.
module tb_dca_matrix_lsu_rdata_aligner;

    logic         clk = 1'b0;
    logic         rstnn;
    logic         txn_valid;
    logic         txn_ready;
    logic [4:0]   txn_bitoffset;
    logic [7:0]   txn_alen;
    logic [2:0]   txn_addr_lsa_p3;
    logic [3:0]   txn_col_mask;
    logic         rvalid;
    logic         rready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         row_valid;
    logic         row_ready;
    logic [127:0] row_data;
    logic         err_flag;
    logic         err_clear;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

`ifdef DCA_RDATA_ALIGNER_RRESP_CHECK_EN
    localparam logic EXP_RRESP_ERR = 1'b1;
`else
    localparam logic EXP_RRESP_ERR = 1'b0;
`endif

    localparam logic [127:0] ROW_T1   = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] ROW_T2   = 128'h100F0E0D_0C0B0A09_08070605_04030201;
    localparam logic [127:0] ROW_O8A3 = 128'h000F0E0D_0C0B0A09_08070605_04030201;

    dca_matrix_lsu_rdata_aligner #(
        .BW_AXI_DATA    (32),
        .BW_ROW_BUFFER  (128),
        .MATRIX_NUM_COL (4)
    ) dut (
        .clk             (clk),
        .rstnn           (rstnn),
        .txn_valid       (txn_valid),
        .txn_ready       (txn_ready),
        .txn_bitoffset   (txn_bitoffset),
        .txn_alen        (txn_alen),
        .txn_addr_lsa_p3 (txn_addr_lsa_p3),
        .txn_col_mask    (txn_col_mask),
        .rvalid          (rvalid),
        .rready          (rready),
        .rdata           (rdata),
        .rresp           (rresp),
        .rlast           (rlast),
        .row_valid       (row_valid),
        .row_ready       (row_ready),
        .row_data        (row_data),
        .err_flag        (err_flag),
        .err_clear       (err_clear)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int unsigned i);
        logic [7:0] b;
        b = 8'(4 * i);
        case (i)
            5:       return 32'hDEADBEEF;
            6:       return 32'hCAFEF00D;
            default: return {b + 8'd3, b + 8'd2, b + 8'd1, b};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_txn(input logic [4:0] ofs, input logic [7:0] alen,
                             input logic [2:0] lsa, input logic [3:0] mask);
        txn_valid       = 1'b1;
        txn_bitoffset   = ofs;
        txn_alen        = alen;
        txn_addr_lsa_p3 = lsa;
        txn_col_mask    = mask;
        step();
        txn_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [1:0] resp, input logic last);
        rvalid = 1'b1;
        rdata  = d;
        rresp  = resp;
        rlast  = last;
        step();
        rvalid = 1'b0;
        rresp  = 2'b00;
        rlast  = 1'b0;
    endtask

    // Runs a transaction up to the first cycle the row should be valid (T+2).
    task automatic do_row(input logic [4:0] ofs, input logic [7:0] alen, input logic [2:0] lsa,
                          input logic [3:0] mask, input int unsigned nbeats);
        start_txn(ofs, alen, lsa, mask);
        for (int unsigned i = 0; i < nbeats; i++) begin
            send_beat(pat(i), 2'b00, i == nbeats - 1);
        end
        step();
    endtask

    task automatic finish_row();
        row_ready = 1'b1;
        step();
        row_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstnn = 1'b1;
        txn_valid = 1'b0; txn_bitoffset = '0; txn_alen = '0; txn_addr_lsa_p3 = '0;
        txn_col_mask = '0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
        row_ready = 1'b0; err_clear = 1'b0;
        #2 rstnn = 1'b0;
        #10;
        n_tests++; if (txn_ready !== 1'b1) begin n_fail++; $display("FAIL reset_txn_ready got %0b exp 1", txn_ready); end
        n_tests++; if (rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready got %0b exp 0", rready); end
        n_tests++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL reset_row_valid got %0b exp 0", row_valid); end
        n_tests++; if (row_data !== 128'h0) begin n_fail++; $display("FAIL reset_row_data got %h exp 0", row_data); end
        n_tests++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b exp 0", err_flag); end
        @(posedge clk);
        #1 rstnn = 1'b1;
        step();
        n_tests++; if (txn_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_txn_ready got %0b exp 1", txn_ready); end
    endtask

    task automatic test_aligned();
        start_txn(5'd0, 8'd3, 3'd5, 4'hF);
        n_tests++; if (rready !== 1'b1) begin n_fail++; $display("FAIL t1_rready got %0b exp 1", rready); end
        n_tests++; if (txn_ready !== 1'b0) begin n_fail++; $display("FAIL t1_txn_ready got %0b exp 0", txn_ready); end
        for (int unsigned i = 0; i < 4; i++) send_beat(pat(i), 2'b00, i == 3);
        n_tests++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL t1_valid_early got %0b exp 0", row_valid); end
        n_tests++; if (rready !== 1'b0) begin n_fail++; $display("FAIL t1_rready_align got %0b exp 0", rready); end
        step();
        n_tests++; if (row_valid !== 1'b1) begin n_fail++; $display("FAIL t1_row_valid got %0b exp 1", row_valid); end
        n_tests++; if (row_data !== ROW_T1) begin n_fail++; $display("FAIL t1_row_data got %h exp %h", row_data, ROW_T1); end
        n_tests++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL t1_err got %0b exp 0", err_flag); end
        finish_row();
        n_tests++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL t1_valid_drop got %0b exp 0", row_valid); end
        n_tests++; if (txn_ready !== 1'b1) begin n_fail++; $display("FAIL t1_idle got %0b exp 1", txn_ready); end
    endtask

    task automatic test_offset();
        do_row(5'd8, 8'd4, 3'd5, 4'hF, 5);
        n_tests++; if (row_valid !== 1'b1) begin n_fail++; $display("FAIL t2_row_valid got %0b exp 1", row_valid); end
        n_tests++; if (row_data !== ROW_T2) begin n_fail++; $display("FAIL t2_row_data got %h exp %h", row_data, ROW_T2); end
        n_tests++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL t2_err got %0b exp 0", err_flag); end
        finish_row();
    endtask

    task automatic test_mask();
        logic [127:0] e;
        do_row(5'd0, 8'd3, 3'd5, 4'b0101, 4);
        e = 128'h00000000_0B0A0908_00000000_03020100;
        n_tests++; if (row_data !== e) begin n_fail++; $display("FAIL mask_0101 got %h exp %h", row_data, e); end
        finish_row();
        do_row(5'd0, 8'd3, 3'd3, 4'b0011, 4);
        e = 128'h0100;
        n_tests++; if (row_data !== e) begin n_fail++; $display("FAIL mask_lsa3 got %h exp %h", row_data, e); end
        finish_row();
        do_row(5'd0, 8'd3, 3'd6, 4'b0010, 4);
        e = 128'h00000000_00000000_07060504_00000000;
        n_tests++; if (row_data !== e) begin n_fail++; $display("FAIL mask_lsa6_sat got %h exp %h", row_data, e); end
        finish_row();
    endtask

    task automatic test_back_to_back();
        do_row(5'd8, 8'd4, 3'd5, 4'hF, 5);
        rvalid = 1'b1;
        rdata  = 32'hFFFFFFFF;
        for (int unsigned k = 0; k < 5; k++) begin
            n_tests++; if (row_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %0b exp 1", k, row_valid); end
            n_tests++; if (row_data !== ROW_T2) begin n_fail++; $display("FAIL stall_data[%0d] got %h exp %h", k, row_data, ROW_T2); end
            n_tests++; if (rready !== 1'b0) begin n_fail++; $display("FAIL stall_rready[%0d] got %0b exp 0", k, rready); end
            n_tests++; if (txn_ready !== 1'b0) begin n_fail++; $display("FAIL stall_txn_ready[%0d] got %0b exp 0", k, txn_ready); end
            step();
        end
        rvalid = 1'b0;
        finish_row();
        n_tests++; if (txn_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle got %0b exp 1", txn_ready); end
        start_txn(5'd8, 8'd3, 3'd5, 4'hF);
        n_tests++; if (rready !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %0b exp 1", rready); end
        for (int unsigned i = 0; i < 4; i++) send_beat(pat(i), 2'b00, i == 3);
        step();
        n_tests++; if (row_data !== ROW_O8A3) begin n_fail++; $display("FAIL b2b_buf_clear got %h exp %h", row_data, ROW_O8A3); end
        finish_row();
    endtask

    task automatic test_overflow_beats();
        logic [127:0] e;
        do_row(5'd16, 8'd6, 3'd5, 4'hF, 7);
        e = 128'h11100F0E_0D0C0B0A_09080706_05040302;
        n_tests++; if (row_data !== e) begin n_fail++; $display("FAIL ovf_row_data got %h exp %h", row_data, e); end
        n_tests++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL ovf_err got %0b exp 0", err_flag); end
        finish_row();
    endtask

    task automatic test_rlast_err();
        logic [127:0] e;
        start_txn(5'd0, 8'd3, 3'd5, 4'hF);
        for (int unsigned i = 0; i < 3; i++) send_beat(pat(i), 2'b00, i == 2);
        n_tests++; if (err_flag !== 1'b1) begin n_fail++; $display("FAIL rlast_err_set got %0b exp 1", err_flag); end
        step();
        e = 128'h00000000_0B0A0908_07060504_03020100;
        n_tests++; if (row_valid !== 1'b1) begin n_fail++; $display("FAIL rlast_row_valid got %0b exp 1", row_valid); end
        n_tests++; if (row_data !== e) begin n_fail++; $display("FAIL rlast_row_data got %h exp %h", row_data, e); end
        finish_row();
        n_tests++; if (err_flag !== 1'b1) begin n_fail++; $display("FAIL rlast_err_sticky got %0b exp 1", err_flag); end
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        n_tests++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL rlast_err_clear got %0b exp 0", err_flag); end
        err_clear = 1'b1;
        start_txn(5'd0, 8'd3, 3'd5, 4'hF);
        send_beat(pat(0), 2'b00, 1'b0);
        send_beat(pat(1), 2'b00, 1'b1);
        n_tests++; if (err_flag !== 1'b1) begin n_fail++; $display("FAIL set_wins got %0b exp 1", err_flag); end
        step();
        err_clear = 1'b0;
        n_tests++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL clear_after_set got %0b exp 0", err_flag); end
        finish_row();
    endtask

    task automatic test_rresp_and_reset();
        start_txn(5'd0, 8'd3, 3'd5, 4'hF);
        for (int unsigned i = 0; i < 4; i++) send_beat(pat(i), (i == 1) ? 2'b10 : 2'b00, i == 3);
        step();
        n_tests++; if (row_data !== ROW_T1) begin n_fail++; $display("FAIL rresp_row_data got %h exp %h", row_data, ROW_T1); end
        n_tests++; if (err_flag !== EXP_RRESP_ERR) begin n_fail++; $display("FAIL rresp_err got %0b exp %0b", err_flag, EXP_RRESP_ERR); end
        finish_row();
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        start_txn(5'd0, 8'd3, 3'd5, 4'hF);
        send_beat(pat(0), 2'b00, 1'b0);
        send_beat(pat(1), 2'b00, 1'b0);
        rstnn = 1'b0;
        #1;
        n_tests++; if (rready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rready got %0b exp 0", rready); end
        n_tests++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %0b exp 0", row_valid); end
        step();
        step();
        rstnn = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            step();
            n_tests++; if (row_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_row[%0d] got %0b exp 0", k, row_valid); end
            n_tests++; if (txn_ready !== 1'b1) begin n_fail++; $display("FAIL rst_txn_ready[%0d] got %0b exp 1", k, txn_ready); end
        end
        n_tests++; if (row_data !== 128'h0) begin n_fail++; $display("FAIL rst_row_data got %h exp 0", row_data); end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_offset();
        test_mask();
        test_back_to_back();
        test_overflow_beats();
        test_rlast_err();
        test_rresp_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
